// File: rtl/expo_norm_if.sv
// Handshake bundle between the FP32 adder align/add stage, expo_norm and the
// result consumer. The slave modport is the normalizer's view.
interface expo_norm_if;
  logic        In_valid;
  logic        In_ready;
  logic        Sign;
  logic [7:0]  Exp;
  logic [27:0] Mant;
  logic        Out_valid;
  logic        Out_ready;
  logic [31:0] Result;
  logic        Overflow;
  logic        Inexact;

  modport master (
    output In_valid, Sign, Exp, Mant, Out_ready,
    input  In_ready, Out_valid, Result, Overflow, Inexact
  );

  modport slave (
    input  In_valid, Sign, Exp, Mant, Out_ready,
    output In_ready, Out_valid, Result, Overflow, Inexact
  );
endinterface

// File: rtl/expo_norm.sv
// FP32 adder post-add stage: iterative renormalization (one bit per cycle),
// round-to-nearest-even and IEEE-754 single packing behind a valid/ready pair.
module expo_norm (
  input  logic        clk_i,
  input  logic        rst_i,
  expo_norm_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t             state;
  logic               s;
  logic signed [9:0]  e;
  logic [27:0]        m;
  logic               in_ready;
  logic               out_valid;
  logic [31:0]        result;
  logic               overflow;
  logic               inexact;

  logic               lsb;
  logic               g;
  logic               r;
  logic               st;
  logic               inc;
  logic [24:0]        sum25;
  logic [22:0]        frac;
  logic signed [9:0]  e_rnd;
  logic               ovf;

  // Rounding datapath, consumed only in ROUND.
  always_comb begin
    lsb   = m[3];
    g     = m[2];
    r     = m[1];
    st    = m[0];
    inc   = g & (r | st | lsb);
    sum25 = {1'b0, m[26:3]} + {24'd0, inc};
    frac  = sum25[22:0];
    e_rnd = e;
    if (sum25[24]) begin
      frac  = '0;
      e_rnd = e + 10'sd1;
    end else if ((e == 10'sd0) && sum25[23]) begin
      e_rnd = 10'sd1;
    end
    ovf = (e_rnd >= 10'sd255);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      s         <= 1'b0;
      e         <= '0;
      m         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.In_valid && in_ready) begin
            s        <= bus.Sign;
            e        <= (bus.Exp == 8'd0) ? 10'sd1 : $signed({2'b00, bus.Exp});
            m        <= bus.Mant;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          if (m == '0) begin
            result    <= {s, 31'b0};
            overflow  <= 1'b0;
            inexact   <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (m[27]) begin
            // Carry out: right shift, folding the dropped bit into sticky.
            m     <= {1'b0, m[27:2], m[1] | m[0]};
            e     <= e + 10'sd1;
            state <= ROUND;
          end else if (!m[26] && (e > 10'sd1)) begin
            m <= {m[26:0], 1'b0};
            e <= e - 10'sd1;
          end else begin
            if (!m[26]) begin
              e <= '0;
            end
            state <= ROUND;
          end
        end
        ROUND: begin
          result    <= ovf ? {s, 8'hFF, 23'b0} : {s, e_rnd[7:0], frac};
          overflow  <= ovf;
          inexact   <= g | r | st;
          e         <= e_rnd;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (bus.Out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = out_valid;
  assign bus.Result    = result;
  assign bus.Overflow  = overflow;
  assign bus.Inexact   = inexact;

endmodule

// File: tb/tb_expo_norm.sv
// Self-checking bench for expo_norm: directed vectors, handshake/reset
// scenarios and random bundles against an exact-arithmetic rounding model.
module tb_expo_norm;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  expo_norm_if bus ();

  expo_norm dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact value is Mant * 2^(Eeff-153); round to 24 significant bits with
  // minimum exponent 1, ties to even, using wide integers.
  function automatic void ref_model(input logic sgn, input logic [7:0] ex,
                                    input logic [27:0] mt,
                                    output logic [31:0] res, output logic ovf,
                                    output logic inx, output int lat);
    int ee, p, xe, n, k;
    logic [63:0] full, q, rem, half;
    logic up;
    ee = (ex == 8'd0) ? 1 : int'(ex);
    if (mt == 28'd0) begin
      res = {sgn, 31'b0}; ovf = 1'b0; inx = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (mt[i]) p = i;
    xe = ee + p - 26;
    if (xe < 1) xe = 1;
    n    = 3 + xe - ee + 32;
    full = {36'd0, mt} << 32;
    q    = full >> n;
    rem  = full & ((64'd1 << n) - 64'd1);
    half = 64'd1 << (n - 1);
    up   = (rem > half) || ((rem == half) && q[0]);
    q    = q + {63'd0, up};
    if (q[24]) begin
      q  = q >> 1;
      xe = xe + 1;
    end
    inx = (rem != 64'd0);
    if (xe >= 255) begin
      res = {sgn, 8'hFF, 23'b0}; ovf = 1'b1;
    end else begin
      res = {sgn, (q[23] ? xe[7:0] : 8'd0), q[22:0]}; ovf = 1'b0;
    end
    if (p >= 26) lat = 2;
    else begin
      k = 26 - p;
      if (k > ee - 1) k = ee - 1;
      lat = 2 + k;
    end
  endfunction

  task automatic run_op(input logic sg, input logic [7:0] ex, input logic [27:0] mt,
                        input int hold, output logic [31:0] res, output logic ovf,
                        output logic inx, output int lat, output int acc,
                        output logic to);
    int n;
    to = 1'b0; res = '0; ovf = 1'b0; inx = 1'b0; lat = 0; acc = 0;
    @(negedge clk);
    n = 0;
    while (!bus.In_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.In_ready) begin to = 1'b1; return; end
    bus.Sign = sg; bus.Exp = ex; bus.Mant = mt; bus.In_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    bus.In_valid = 1'b0;
    bus.Sign = 1'($urandom); bus.Exp = 8'($urandom); bus.Mant = 28'($urandom);
    @(negedge clk);
    while (!bus.Out_valid && lat < 60) begin @(negedge clk); lat++; end
    if (!bus.Out_valid) begin to = 1'b1; return; end
    res = bus.Result; ovf = bus.Overflow; inx = bus.Inexact;
    repeat (hold) @(negedge clk);
    bus.Out_ready = 1'b1;
    @(posedge clk); #1;
    bus.Out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (bus.In_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.In_ready); end
    tests++; if (bus.Out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.Out_valid); end
    tests++; if (bus.Result !== 32'd0) begin fails++; $display("FAIL reset_result got=%h exp=00000000", bus.Result); end
    tests++; if ({bus.Overflow, bus.Inexact} !== 2'b00) begin fails++; $display("FAIL reset_flags got=%b exp=00", {bus.Overflow, bus.Inexact}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic        sg [10];
    logic [7:0]  ex [10];
    logic [27:0] mt [10];
    logic [31:0] er [10];
    logic        eo [10];
    logic        ei [10];
    int          el [10];
    logic [31:0] res; logic ovf, inx, to; int lat, acc;
    sg = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    ex = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd254, 8'd127, 8'd127, 8'd1, 8'd0, 8'd0};
    mt = '{28'h8000000, 28'h0000008, 28'h4000004, 28'h400000C, 28'h8000000,
           28'h7FFFFFC, 28'h0000000, 28'h0000010, 28'h3FFFFFC, 28'h4000000};
    er = '{32'h40000000, 32'h34000000, 32'h3F800000, 32'h3F800002, 32'h7F800000,
           32'h40000000, 32'h80000000, 32'h00000002, 32'h80800000, 32'h00800000};
    eo = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    ei = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 0};
    el = '{2, 25, 2, 2, 2, 2, 1, 2, 2, 2};
    for (int i = 0; i < 10; i++) begin
      run_op(sg[i], ex[i], mt[i], 0, res, ovf, inx, lat, acc, to);
      tests++;
      if (to) begin fails++; $display("FAIL dir%0d_timeout got=timeout exp=Out_valid", i); continue; end
      if (res !== er[i]) begin fails++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, er[i]); end
      tests++; if (ovf !== eo[i]) begin fails++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, ovf, eo[i]); end
      tests++; if (inx !== ei[i]) begin fails++; $display("FAIL dir%0d_inexact got=%b exp=%b", i, inx, ei[i]); end
      tests++; if (lat != el[i]) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, er; logic ovf, inx, to, eo, ei; int lat, acc, el;
    logic sg; logic [7:0] ex; logic [27:0] mt; logic [31:0] raw;
    for (int i = 0; i < 300; i++) begin
      sg  = 1'($urandom);
      raw = $urandom;
      mt  = raw[27:0] >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) mt = '0;
      case ($urandom_range(0, 3))
        0:       ex = 8'($urandom_range(0, 3));
        1:       ex = 8'($urandom_range(250, 254));
        default: ex = 8'($urandom_range(0, 254));
      endcase
      ref_model(sg, ex, mt, er, eo, ei, el);
      run_op(sg, ex, mt, $urandom_range(0, 3), res, ovf, inx, lat, acc, to);
      tests++;
      if (to) begin fails++; $display("FAIL rnd%0d_timeout got=timeout exp=Out_valid", i); continue; end
      if (res !== er) begin fails++; $display("FAIL rnd%0d_result s=%b e=%h m=%h got=%h exp=%h", i, sg, ex, mt, res, er); end
      tests++; if (ovf !== eo) begin fails++; $display("FAIL rnd%0d_overflow got=%b exp=%b", i, ovf, eo); end
      tests++; if (inx !== ei) begin fails++; $display("FAIL rnd%0d_inexact got=%b exp=%b", i, inx, ei); end
      tests++; if (lat != el) begin fails++; $display("FAIL rnd%0d_latency e=%h m=%h got=%0d exp=%0d", i, ex, mt, lat, el); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] er; logic eo, ei; int el, n, extra; logic bad;
    ref_model(1'b0, 8'd130, 28'h5A5A5A7, er, eo, ei, el);
    @(negedge clk);
    n = 0;
    while (!bus.In_ready && n < 100) begin @(negedge clk); n++; end
    bus.Sign = 1'b0; bus.Exp = 8'd130; bus.Mant = 28'h5A5A5A7; bus.In_valid = 1'b1;
    @(posedge clk); #1;
    bus.Mant = 28'h0000001; bus.Exp = 8'd3;
    n = 0;
    @(negedge clk);
    while (!bus.Out_valid && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (!bus.Out_valid) begin fails++; $display("FAIL bp_timeout got=timeout exp=Out_valid"); bus.In_valid = 1'b0; return; end
    if (bus.Result !== er) begin fails++; $display("FAIL bp_result got=%h exp=%h", bus.Result, er); end
    bad = 1'b0;
    repeat (10) begin
      if (bus.Result !== er || bus.In_ready !== 1'b0 || bus.Out_valid !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    tests++; if (bad) begin fails++; $display("FAIL bp_hold got=unstable exp=stable Result/Out_valid=1/In_ready=0"); end
    bus.In_valid = 1'b0;
    bus.Out_ready = 1'b1;
    @(posedge clk); #1;
    bus.Out_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus.Out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got=%b exp=0", bus.Out_valid); end
    tests++; if (bus.In_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", bus.In_ready); end
    extra = 0;
    repeat (5) begin @(negedge clk); if (bus.Out_valid) extra++; end
    tests++; if (extra != 0) begin fails++; $display("FAIL bp_single_transfer got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_norm();
    logic [31:0] res; logic ovf, inx, to; int n, seen, lat, acc;
    @(negedge clk);
    n = 0;
    while (!bus.In_ready && n < 100) begin @(negedge clk); n++; end
    bus.Sign = 1'b0; bus.Exp = 8'd127; bus.Mant = 28'h0000008; bus.In_valid = 1'b1;
    @(posedge clk); #1;
    bus.In_valid = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (bus.In_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b exp=0", bus.In_ready); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.In_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.In_ready); end
    tests++; if (bus.Out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.Out_valid); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.Out_valid) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL rst_mid_spurious got=%0d exp=0", seen); end
    run_op(1'b0, 8'd127, 28'h8000000, 0, res, ovf, inx, lat, acc, to);
    tests++; if (to || res !== 32'h40000000) begin fails++; $display("FAIL rst_mid_recover got=%h exp=40000000", res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; logic o1, o2, i1, i2, t1, t2; int l1, l2, a1, a2;
    run_op(1'b0, 8'd127, 28'h8000000, 0, r1, o1, i1, l1, a1, t1);
    run_op(1'b1, 8'd100, 28'h0400000, 0, r2, o2, i2, l2, a2, t2);
    tests++; if (t1 || r1 !== 32'h40000000) begin fails++; $display("FAIL b2b_first got=%h exp=40000000", r1); end
    tests++; if (t2 || r2 !== 32'hB0000000) begin fails++; $display("FAIL b2b_second got=%h exp=B0000000", r2); end
    tests++; if (a2 - a1 != 4) begin fails++; $display("FAIL b2b_interval got=%0d exp=4", a2 - a1); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0;
    bus.In_valid = 1'b0; bus.Sign = 1'b0; bus.Exp = '0; bus.Mant = '0; bus.Out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
